width_converter_8ton: RTL and testbench
=======================================

# width_converter_8toN

Byte-to-word packer for the I3C target RX path. It collects 8-bit bytes from the target FSM and emits N-bit words to the TTI RX queue, N a multiple of 8. It is the counterpart of the TX-side N-to-8 serializer and uses the same little-endian byte order: the first received byte lands in bits [7:0]. Optional flush support emits a partially filled word at the end of a transfer.

## Interface
Parameters:
- Width, 32, output word width in bits; must be a multiple of 8 and at least 16. Elaboration-time `$error` otherwise.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset; asynchronous, active-low
- sink_valid_i  input  1  byte valid from target FSM
- sink_ready_o  output  1  packer can accept a byte this cycle
- sink_data_i  input  8  byte
- flush_i  input  1  end-of-transfer request; close the current partial word
- source_valid_o  output  1  word valid towards RX queue
- source_ready_i  input  1  RX queue accepts the word
- source_data_o  output  Width  packed word
- source_bytes_o  output  $clog2(Width/8)+1  number of valid bytes in source_data_o; 0 when source_valid_o=0

## Operation
- Bytes = Width/8.
- State:
  - fill counter bcnt, range 0..Bytes
  - word register sreg
  - output flag vld
- Byte accept: `sink_valid_i & sink_ready_o`.
  - The byte is written to sreg[8*bcnt +: 8].
  - bcnt increments.
  - When the write index is 0, all other bytes of sreg are cleared in the same cycle. This gives zero padding.
- When bcnt reaches Bytes, vld is set and source_bytes_o = Bytes.
- Word accept: `source_valid_o & source_ready_i`. vld clears and bcnt returns to 0.
- sink_ready_o = !vld | source_ready_i.
  - A byte offered in the same cycle a word drains is accepted.
  - That byte is written at index 0 and bcnt becomes 1.
  - Result: no bubble on the byte side.
- source_valid_o = vld. source_data_o = sreg. source_bytes_o = vld ? bcnt : 0.
- Flush (macro enabled only):
  - flush_i is sampled while vld=0.
  - If bcnt>0, or a byte is accepted in the same cycle, vld is set.
  - The emitted word holds bcnt bytes, counting that same-cycle byte; upper bytes are 0.
  - flush_i with bcnt=0 and no byte accepted has no effect.
  - flush_i while vld=1 is ignored, including in the cycle the word drains.
- source_data_o and source_bytes_o are stable while source_valid_o=1 and source_ready_i=0.

## Timing
- Reset values:
  - sink_ready_o=1, source_valid_o=0, source_data_o=0, source_bytes_o=0
  - internally bcnt=0, sreg=0
- Latency:
  - A word becomes valid in the cycle after its last byte is accepted, or after the flush cycle.
  - Sustained throughput is 1 byte/cycle when source_ready_i=1.
- Backpressure: while vld=1 and source_ready_i=0, sink_ready_o=0 and no byte is accepted.
- Valid is never withdrawn without a word accept.
- Simultaneous word drain and byte accept are both honoured in one cycle, as described under Operation.
- Reset mid-operation discards any partial word and any pending output word immediately (asynchronous); no output is produced.
- All outputs are functions of registers plus source_ready_i. There is no combinational path from sink_* to source_*.

## Configuration
- Macro: I3C_WIDTH_CONV_FLUSH_EN.
- Defined: flush_i behaves as specified. source_bytes_o reports 1..Bytes for a valid word.
- Undefined:
  - flush_i is ignored; the port stays present.
  - Words are emitted only when full.
  - source_bytes_o is Bytes when valid and 0 otherwise.
  - Partial bytes are retained until filled or reset.

## Test plan
- Width=32 stream, source_ready_i=1.
  - Stimulus: bytes 0x11,0x22,0x33,0x44 on consecutive cycles.
  - Response: source_data_o=0x44332211 and source_bytes_o=4, valid one cycle after 0x44.
  - Then 0x55..0x88 back-to-back; sink_ready_o stays 1 and the second word is 0x88776655.
- Backpressure.
  - Stimulus: hold source_ready_i=0 after the word fills.
  - Response: sink_ready_o=0 and data stable for 5 cycles.
  - Release with a byte 0xAA offered in the same cycle: word drains, 0xAA is accepted, bcnt=1.
- Flush, macro on.
  - Stimulus: bytes 0xDE,0xAD, then flush_i.
  - Response: source_data_o=0x0000ADDE, source_bytes_o=2.
  - Next word has no stale 0xAD byte.
- Flush edge cases, macro on.
  - flush_i with bcnt=0: no output.
  - flush_i in the same cycle as byte 0x5A with bcnt=0: word 0x0000005A with source_bytes_o=1.
  - flush_i while vld=1: ignored.
- Flush disabled, macro off.
  - Stimulus: 2 bytes plus flush_i.
  - Response: no output; 2 more bytes then complete a 4-byte word.
- Reset mid-word.
  - Stimulus: assert rst_ni=0 after 3 bytes.
  - Response: all outputs at reset values; the next 4 bytes form a clean word.

Source files
------------

// File: rtl/width_converter_8ton_if.sv
// Handshake bundle between the I3C target FSM byte stream and the TTI RX word queue.
// The slave modport is the packer's view; the master modport is the driver/monitor view.
interface width_converter_8ton_if #(
  parameter int Width = 32
);
  localparam int BytesW = $clog2(Width / 8) + 1;

  logic              sink_valid_i;
  logic              sink_ready_o;
  logic [7:0]        sink_data_i;
  logic              flush_i;
  logic              source_valid_o;
  logic              source_ready_i;
  logic [Width-1:0]  source_data_o;
  logic [BytesW-1:0] source_bytes_o;

  modport slave (
    input  sink_valid_i, sink_data_i, flush_i, source_ready_i,
    output sink_ready_o, source_valid_o, source_data_o, source_bytes_o
  );

  modport master (
    output sink_valid_i, sink_data_i, flush_i, source_ready_i,
    input  sink_ready_o, source_valid_o, source_data_o, source_bytes_o
  );
endinterface

// File: rtl/width_converter_8ton.sv
// Little-endian byte-to-word packer for the I3C target RX path (first byte in bits [7:0]).
// Define I3C_WIDTH_CONV_FLUSH_EN to let flush_i emit a partially filled, zero-padded word.
module width_converter_8ton #(
  parameter int Width = 32
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  width_converter_8ton_if.slave bus
);
  localparam int Bytes = Width / 8;
  localparam int BW    = $clog2(Bytes) + 1;
  localparam logic [BW-1:0] BytesC = BW'(Bytes);

  if (((Width % 8) != 0) || (Width < 16)) begin : g_bad_width
    $error("width_converter_8ton: Width must be a multiple of 8 and at least 16");
  end

  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [Width-1:0] sreg_q, sreg_d;
  logic             vld_q, vld_d;
  logic             byte_acc, word_acc;
  logic [BW-1:0]    wr_idx;

  assign bus.sink_ready_o   = !vld_q || bus.source_ready_i;
  assign bus.source_valid_o = vld_q;
  assign bus.source_data_o  = sreg_q;
  assign bus.source_bytes_o = vld_q ? bcnt_q : '0;

  assign byte_acc = bus.sink_valid_i && bus.sink_ready_o;
  assign word_acc = vld_q && bus.source_ready_i;

`ifndef I3C_WIDTH_CONV_FLUSH_EN
  logic unused_flush;
  assign unused_flush = bus.flush_i;
`endif

  // A draining word frees the register in the same cycle, so the incoming byte restarts at index 0.
  always_comb begin
    bcnt_d = bcnt_q;
    sreg_d = sreg_q;
    vld_d  = vld_q;
    wr_idx = word_acc ? '0 : bcnt_q;

    if (word_acc) begin
      vld_d  = 1'b0;
      bcnt_d = '0;
    end

    if (byte_acc) begin
      if (wr_idx == '0) begin
        sreg_d = {{(Width-8){1'b0}}, bus.sink_data_i};
      end else begin
        for (int i = 1; i < Bytes; i++) begin
          if (wr_idx == BW'(i)) begin
            sreg_d[8*i +: 8] = bus.sink_data_i;
          end
        end
      end
      bcnt_d = wr_idx + 1'b1;
      if (bcnt_d == BytesC) begin
        vld_d = 1'b1;
      end
    end

`ifdef I3C_WIDTH_CONV_FLUSH_EN
    if (!vld_q && bus.flush_i && (bcnt_d != '0)) begin
      vld_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bcnt_q <= '0;
      sreg_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      bcnt_q <= bcnt_d;
      sreg_q <= sreg_d;
      vld_q  <= vld_d;
    end
  end
endmodule

// File: tb/tb_width_converter_8ton.sv
// Self-checking bench for width_converter_8ton (Width=32); flush scenarios follow I3C_WIDTH_CONV_FLUSH_EN.
module tb_width_converter_8ton;
  localparam int Width = 32;
  localparam int Bytes = Width / 8;
  localparam int BW    = $clog2(Bytes) + 1;
`ifdef I3C_WIDTH_CONV_FLUSH_EN
  localparam bit FlushEn = 1'b1;
`else
  localparam bit FlushEn = 1'b0;
`endif

  typedef struct packed {
    logic [Width-1:0] data;
    logic [BW-1:0]    bytes;
  } exp_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  exp_t             exp_q[$];
  logic [Width-1:0] mdl_word = '0;
  int               mdl_cnt  = 0;

  width_converter_8ton_if #(.Width(Width)) bus ();

  width_converter_8ton #(.Width(Width)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard: every word accept seen on the falling edge must match the oldest expected word.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni && bus.source_valid_o && bus.source_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL sb_unexpected_word got data=%h bytes=%0d, none expected",
                 bus.source_data_o, bus.source_bytes_o);
      end else begin
        e = exp_q.pop_front();
        if (bus.source_data_o !== e.data || bus.source_bytes_o !== e.bytes) begin
          failures++;
          $display("[TB] FAIL sb_word got data=%h bytes=%0d, expected data=%h bytes=%0d",
                   bus.source_data_o, bus.source_bytes_o, e.data, e.bytes);
        end
      end
    end
  end

  // Reference packer: called for every byte the bench knows will be accepted.
  function automatic void model_byte(input logic [7:0] b, input bit fl);
    if (mdl_cnt == 0) mdl_word = '0;
    mdl_word[8*mdl_cnt +: 8] = b;
    mdl_cnt++;
    if (mdl_cnt == Bytes || (FlushEn && fl)) begin
      exp_q.push_back('{data: mdl_word, bytes: BW'(mdl_cnt)});
      mdl_cnt = 0;
    end
  endfunction

  function automatic void model_flush();
    if (FlushEn && mdl_cnt > 0) begin
      exp_q.push_back('{data: mdl_word, bytes: BW'(mdl_cnt)});
      mdl_cnt = 0;
    end
  endfunction

  task automatic drive(input bit v, input logic [7:0] d, input bit fl, input bit rdy);
    bus.sink_valid_i   = v;
    bus.sink_data_i    = d;
    bus.flush_i        = fl;
    bus.source_ready_i = rdy;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_word(input string name, input bit v, input logic [Width-1:0] d,
                            input logic [BW-1:0] n);
    checks++;
    if (bus.source_valid_o !== v || bus.source_data_o !== d || bus.source_bytes_o !== n) begin
      failures++;
      $display("[TB] FAIL %s got valid=%b data=%h bytes=%0d, expected valid=%b data=%h bytes=%0d",
               name, bus.source_valid_o, bus.source_data_o, bus.source_bytes_o, v, d, n);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    drive(0, 8'h00, 0, 1);
    checks++;
    if (bus.sink_ready_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_ready got=%b expected=1", bus.sink_ready_o);
    end
    check_word("reset_outputs", 1'b0, '0, '0);
    rst_ni = 1'b1;
    drive(0, 8'h00, 0, 1);
    check_word("after_reset_idle", 1'b0, '0, '0);
  endtask

  task automatic test_stream();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b = 8'(8'h11 * (i + 1));
      checks++;
      if (bus.sink_ready_o !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stream_ready byte=%h got=%b expected=1", b, bus.sink_ready_o);
      end
      model_byte(b, 0);
      drive(1, b, 0, 1);
      if (i == 3) check_word("stream_word1", 1'b1, 32'h44332211, 3'd4);
      if (i == 4) check_word("stream_drain_with_byte", 1'b0, 32'h00000055, 3'd0);
    end
    check_word("stream_word2", 1'b1, 32'h88776655, 3'd4);
    drive(0, 8'h00, 0, 1);
    check_word("stream_idle", 1'b0, 32'h88776655, 3'd0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin
      model_byte(8'(8'hA1 + i), 0);
      drive(1, 8'(8'hA1 + i), 0, 0);
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.sink_ready_o !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bp_ready cycle=%0d got=%b expected=0", c, bus.sink_ready_o);
      end
      check_word("bp_hold", 1'b1, 32'hA4A3A2A1, 3'd4);
      drive(1, 8'hEE, 0, 0);
    end
    model_byte(8'hAA, 0);
    drive(1, 8'hAA, 0, 1);
    check_word("bp_release", 1'b0, 32'h000000AA, 3'd0);
    for (int i = 0; i < 3; i++) begin
      model_byte(8'(8'hBB + 8'h11 * i), 0);
      drive(1, 8'(8'hBB + 8'h11 * i), 0, 1);
    end
    check_word("bp_next_word", 1'b1, 32'hDDCCBBAA, 3'd4);
    drive(0, 8'h00, 0, 1);
  endtask

`ifdef I3C_WIDTH_CONV_FLUSH_EN
  task automatic test_flush();
    model_byte(8'hDE, 0);
    drive(1, 8'hDE, 0, 1);
    model_byte(8'hAD, 0);
    drive(1, 8'hAD, 0, 1);
    model_flush();
    drive(0, 8'h00, 1, 1);
    check_word("flush_partial", 1'b1, 32'h0000ADDE, 3'd2);
    drive(0, 8'h00, 0, 1);
    model_byte(8'h77, 0);
    drive(1, 8'h77, 0, 1);
    model_flush();
    drive(0, 8'h00, 1, 1);
    check_word("flush_no_stale", 1'b1, 32'h00000077, 3'd1);
    drive(0, 8'h00, 0, 1);
  endtask

  task automatic test_flush_edges();
    model_flush();
    drive(0, 8'h00, 1, 1);
    check_word("flush_empty", 1'b0, 32'h00000077, 3'd0);
    model_byte(8'h5A, 1);
    drive(1, 8'h5A, 1, 1);
    check_word("flush_with_byte", 1'b1, 32'h0000005A, 3'd1);
    drive(0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) begin
      model_byte(8'(8'h31 + i), 0);
      drive(1, 8'(8'h31 + i), 0, 1);
    end
    drive(0, 8'h00, 1, 0);
    check_word("flush_while_valid", 1'b1, 32'h34333231, 3'd4);
    model_byte(8'h41, 0);
    drive(1, 8'h41, 1, 1);
    check_word("flush_on_drain_ignored", 1'b0, 32'h00000041, 3'd0);
    for (int i = 1; i < 4; i++) begin
      model_byte(8'(8'h41 + i), 0);
      drive(1, 8'(8'h41 + i), 0, 1);
    end
    check_word("flush_after_drain_word", 1'b1, 32'h44434241, 3'd4);
    drive(0, 8'h00, 0, 1);
  endtask
`else
  task automatic test_flush_disabled();
    model_byte(8'h61, 0);
    drive(1, 8'h61, 0, 1);
    model_byte(8'h62, 0);
    drive(1, 8'h62, 0, 1);
    model_flush();
    drive(0, 8'h00, 1, 1);
    check_word("noflush_ignored", 1'b0, 32'h00006261, 3'd0);
    drive(0, 8'h00, 1, 1);
    check_word("noflush_ignored2", 1'b0, 32'h00006261, 3'd0);
    model_byte(8'h63, 0);
    drive(1, 8'h63, 1, 1);
    check_word("noflush_byte_flush", 1'b0, 32'h00636261, 3'd0);
    model_byte(8'h64, 0);
    drive(1, 8'h64, 0, 1);
    check_word("noflush_full_word", 1'b1, 32'h64636261, 3'd4);
    drive(0, 8'h00, 0, 1);
  endtask
`endif

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      model_byte(8'(8'h71 + i), 0);
      drive(1, 8'(8'h71 + i), 0, 1);
    end
    bus.sink_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    mdl_cnt = 0;
    checks++;
    if (bus.sink_ready_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_mid_ready got=%b expected=1", bus.sink_ready_o);
    end
    check_word("reset_mid_outputs", 1'b0, '0, '0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      model_byte(8'(8'h81 + i), 0);
      drive(1, 8'(8'h81 + i), 0, 1);
    end
    check_word("reset_mid_clean_word", 1'b1, 32'h84838281, 3'd4);
    drive(0, 8'h00, 0, 1);
  endtask

  initial begin
    bus.sink_valid_i   = 1'b0;
    bus.sink_data_i    = 8'h00;
    bus.flush_i        = 1'b0;
    bus.source_ready_i = 1'b1;
    #2;
    test_reset();
    test_stream();
    test_backpressure();
`ifdef I3C_WIDTH_CONV_FLUSH_EN
    test_flush();
    test_flush_edges();
`else
    test_flush_disabled();
`endif
    test_reset_mid();
    drive(0, 8'h00, 0, 1);
    drive(0, 8'h00, 0, 1);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_leftover got=%0d words outstanding, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
